// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, and execute redirect.
// Master is the fetch stage; slave is the surrounding memory/decode/execute side.
interface instruction_fetch_if #(
  parameter int INSTRUCTION_SIZE      = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10
);
  logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr;
  logic [INSTRUCTION_SIZE-1:0]      imem_data;
  logic [INSTRUCTION_SIZE-1:0]      out_instr;
  logic [INSTRUCTION_ADDR_SIZE-1:0] out_pc;
  logic                             out_valid;
  logic                             out_ready;
  logic                             redirect_valid;
  logic [INSTRUCTION_ADDR_SIZE-1:0] redirect_addr;
  logic                             halted;

  modport master (
    output imem_addr, out_instr, out_pc, out_valid, halted,
    input  imem_data, out_ready, redirect_valid, redirect_addr
  );

  modport slave (
    input  imem_addr, out_instr, out_pc, out_valid, halted,
    output imem_data, out_ready, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one-entry instruction register, redirect flush and HLT lockout.
// Optional FETCH_PERF_COUNTERS_EN adds saturating perf_fetched/perf_stall counters.
module instruction_fetch #(
  parameter int                             INSTRUCTION_SIZE      = 16,
  parameter int                             INSTRUCTION_ADDR_SIZE = 10,
  parameter logic [INSTRUCTION_ADDR_SIZE-1:0] RESET_PC            = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [15:0]          perf_fetched,
  output logic [15:0]          perf_stall,
`endif
  instruction_fetch_if.master  bus
);
  localparam logic [3:0] OP_HLT = 4'b0001;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t                           state_q, state_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0]      instr_q, instr_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] ir_pc_q, ir_pc_d;
  logic                             valid_q, valid_d;
  logic                             halted_q, halted_d;
  logic                             load;
  logic                             accept;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = valid_q && bus.out_ready;
  assign load   = fetch_en && (state_q == RUN) && (!valid_q || bus.out_ready) && !bus.redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ir_pc_d  = ir_pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (state_q != HALTED) begin
      if (bus.redirect_valid) begin
        // Flush wins over a same-cycle accept; a pending HLT is squashed here.
        pc_d    = bus.redirect_addr;
        valid_d = 1'b0;
        state_d = RUN;
      end else if (load) begin
        instr_d = bus.imem_data;
        ir_pc_d = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + INSTRUCTION_ADDR_SIZE'(1);
        if (bus.imem_data[INSTRUCTION_SIZE-1 -: 4] == OP_HLT) state_d = HALT_PEND;
      end else if (accept) begin
        valid_d = 1'b0;
        if (state_q == HALT_PEND) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
    end
  end

  // ---- stage boundary: memory address -> instruction register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ir_pc_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ir_pc_q  <= ir_pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_pc    = ir_pc_q;
  assign bus.out_valid = valid_q;
  assign bus.halted    = halted_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] fetched_q, fetched_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    fetched_d = load ? sat_inc(fetched_q) : fetched_q;
    stall_d   = (valid_q && !bus.out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; consumed instructions are checked against a scoreboard queue.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n;
  logic fetch_en;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [0:1023];

  instruction_fetch_if #(.INSTRUCTION_SIZE(16), .INSTRUCTION_ADDR_SIZE(10)) bus ();

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  instruction_fetch #(
    .INSTRUCTION_SIZE(16),
    .INSTRUCTION_ADDR_SIZE(10),
    .RESET_PC(10'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
`ifdef FETCH_PERF_COUNTERS_EN
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem[a];
    sb.push_back(e);
  endtask

  // Scoreboard pop for a transfer that the coming edge will complete, then advance one cycle.
  task automatic cyc();
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready && !bus.redirect_valid && rst_n) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pc", {22'd0, bus.out_pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", {22'd0, bus.out_pc}, {22'd0, e.pc});
        chk("sb_instr", {16'd0, bus.out_instr}, {16'd0, e.instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_addr"},   {22'd0, bus.imem_addr}, 32'd0);
    chk({tag, "_instr"},  {16'd0, bus.out_instr}, 32'd0);
    chk({tag, "_pc"},     {22'd0, bus.out_pc},    32'd0);
    chk({tag, "_halted"}, {31'd0, bus.halted},    32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk({tag, "_perf_fetched"}, {16'd0, perf_fetched}, 32'd0);
    chk({tag, "_perf_stall"},   {16'd0, perf_stall},   32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h2000 | 16'(i);
    mem[0]    = 16'h0000;
    mem[1]    = 16'h8101;
    mem[2]    = 16'h8201;
    mem[3]    = 16'h1000;
    mem[1023] = 16'h0000;

    rst_n              = 1'b0;
    fetch_en           = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 10'd0;
    cyc();
    cyc();
    chk_reset("rst0");

    // Straight-line run into HLT
    push(10'd0); push(10'd1); push(10'd2); push(10'd3);
    rst_n = 1'b1;
    cyc();
    chk("first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_pc", {22'd0, bus.out_pc}, 32'd0);
    cyc(); cyc(); cyc();
    chk("hlt_in_ir_pc", {22'd0, bus.out_pc}, 32'd3);
    chk("hlt_not_yet", {31'd0, bus.halted}, 32'd0);
    cyc();
    chk("halted_set", {31'd0, bus.halted}, 32'd1);
    chk("halted_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("halted_addr", {22'd0, bus.imem_addr}, 32'd4);

    // Halted lockout
    bus.redirect_valid = 1'b1; bus.redirect_addr = 10'd0;
    cyc();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0; cyc();
    bus.out_ready = 1'b1; cyc();
    bus.out_ready = 1'b0; cyc();
    bus.out_ready = 1'b1;
    chk("lock_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lock_halted", {31'd0, bus.halted}, 32'd1);
    chk("lock_addr", {22'd0, bus.imem_addr}, 32'd4);
    chk("sb_drain1", sb.size(), 32'd0);

    // Back-pressure with IR at address 2
    rst_n = 1'b0;
    cyc();
    chk_reset("rst1");
    push(10'd0); push(10'd1);
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("bp_pc_pre", {22'd0, bus.out_pc}, 32'd2);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_pc", {22'd0, bus.out_pc}, 32'd2);
      chk("bp_instr", {16'd0, bus.out_instr}, 32'h8201);
      chk("bp_addr", {22'd0, bus.imem_addr}, 32'd3);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_stall", {16'd0, perf_stall}, 32'd3);
    chk("perf_fetched", {16'd0, perf_fetched}, 32'd3);
`endif
    push(10'd2);
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_next_pc", {22'd0, bus.out_pc}, 32'd3);
    chk("bp_next_instr", {16'd0, bus.out_instr}, 32'h1000);

    // Redirect squashes the pending HLT
    bus.redirect_valid = 1'b1; bus.redirect_addr = 10'd5;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rd_halted", {31'd0, bus.halted}, 32'd0);
    chk("rd_addr", {22'd0, bus.imem_addr}, 32'd5);
    push(10'd5); push(10'd6);
    cyc();
    chk("rd_tgt_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rd_tgt_pc", {22'd0, bus.out_pc}, 32'd5);
    chk("rd_tgt_instr", {16'd0, bus.out_instr}, 32'h2005);
    cyc(); cyc();
    chk("mid_pc", {22'd0, bus.out_pc}, 32'd7);
    chk("mid_valid", {31'd0, bus.out_valid}, 32'd1);

    // Reset mid-stream
    rst_n = 1'b0;
    cyc();
    chk_reset("rst2");
    rst_n = 1'b1;
    cyc();
    chk("restart_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("restart_pc", {22'd0, bus.out_pc}, 32'd0);
    chk("restart_addr", {22'd0, bus.imem_addr}, 32'd1);

    // Wrap at the top of the address space
    bus.redirect_valid = 1'b1; bus.redirect_addr = 10'd1023;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("wrap_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("wrap_flush_addr", {22'd0, bus.imem_addr}, 32'd1023);
    push(10'd1023); push(10'd0);
    cyc();
    chk("wrap_pc0", {22'd0, bus.out_pc}, 32'd1023);
    chk("wrap_addr0", {22'd0, bus.imem_addr}, 32'd0);
    cyc();
    chk("wrap_pc1", {22'd0, bus.out_pc}, 32'd0);

    // fetch_en freeze
    fetch_en = 1'b0;
    cyc();
    chk("fe_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fe_addr", {22'd0, bus.imem_addr}, 32'd1);
    cyc();
    chk("fe_addr_hold", {22'd0, bus.imem_addr}, 32'd1);
    fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    cyc();
    chk("fe_resume_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("fe_resume_pc", {22'd0, bus.out_pc}, 32'd1);
    chk("fe_resume_instr", {16'd0, bus.out_instr}, 32'h8101);
    cyc();
    chk("sb_drain2", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
